// File: rtl/l1_sdram_arbiter_pkg.sv
// Shared memory-bus definitions for the L1 <-> SDRAM controller arbiter:
// FSM state encoding, the SDRAM address-range limit and the request record
// that gets captured when a cache wins the controller.
package l1_sdram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [23:0] SDRAM_ADDR_LIMIT = 24'h800000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
   } bus_req_t;

endpackage

// File: rtl/l1_sdram_arbiter_if.sv
// Bundle of the two cache-side request buses, the controller bus and the
// arbiter status. The slave view belongs to the arbiter; the master view
// is the surrounding system (caches plus controller).
interface l1_sdram_arbiter_if;

   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_we;
   logic        i_start;
   logic [31:0] i_q;
   logic        i_done;

   logic [31:0] d_addr;
   logic [31:0] d_data;
   logic        d_we;
   logic        d_start;
   logic [31:0] d_q;
   logic        d_done;

   logic [31:0] sdc_addr;
   logic [31:0] sdc_data;
   logic        sdc_we;
   logic        sdc_start;
   logic [31:0] sdc_q;
   logic        sdc_done;

   logic [1:0]  grant;
   logic        timeout_err;

   modport slave (
      input  i_addr, i_data, i_we, i_start,
      output i_q, i_done,
      input  d_addr, d_data, d_we, d_start,
      output d_q, d_done,
      output sdc_addr, sdc_data, sdc_we, sdc_start,
      input  sdc_q, sdc_done,
      output grant, timeout_err
   );

   modport master (
      output i_addr, i_data, i_we, i_start,
      input  i_q, i_done,
      output d_addr, d_data, d_we, d_start,
      input  d_q, d_done,
      input  sdc_addr, sdc_data, sdc_we, sdc_start,
      output sdc_q, sdc_done,
      input  grant, timeout_err
   );

endinterface

// File: rtl/l1_sdram_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. The pick is combinational so the top can
// latch the winner in the same IDLE cycle; last_grant remembers who won
// the previous transaction so that the other side wins the next tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] pick
);

   logic last_d;

   // One-hot winner {d,i}; on a tie the side that did not win last time goes.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last_d ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

   // Record the winner whenever a grant is actually taken; I is "last" after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_d <= 1'b0;
      else if (take)
         last_d <= pick[1];
   end

endmodule

// File: rtl/l1_sdram_arbiter.sv
// Transaction-level arbiter sharing one SDRAM controller between the L1
// instruction and data caches. The winner's request is captured at grant
// and held on the controller bus until done; a watchdog forces termination
// if the controller never answers.
module l1_sdram_arbiter
   import l1_sdram_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input logic               clk,
   input logic               reset,
   l1_sdram_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   bus_req_t         lat;
   bus_req_t         i_req;
   bus_req_t         d_req;
   bus_req_t         win_req;
   logic [1:0]       req;
   logic [1:0]       pick;
   logic [1:0]       grant_q;
   logic             sdc_start_q;
   logic             timeout_q;
   logic             take;
   logic             busy;
   logic             expire;
   logic             finish;

   assign req     = {bus.d_start, bus.i_start};
   assign take    = (state == ST_IDLE) && (req != 2'b00);
   assign i_req   = '{addr: bus.i_addr, data: bus.i_data, we: bus.i_we};
   assign d_req   = '{addr: bus.d_addr, data: bus.d_data, we: bus.d_we};
   assign win_req = pick[1] ? d_req : i_req;

   rr_arbiter2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .take  (take),
      .pick  (pick)
   );

   // The transaction ends on the controller's done, or on watchdog expiry
   // when the controller stays silent; done itself always wins over expiry.
   assign busy   = (state == ST_BUSY);
   assign expire = busy && (wd_cnt == WD_LAST) && !bus.sdc_done;
   assign finish = busy && (bus.sdc_done || expire);

   assign bus.i_done = finish && grant_q[0];
   assign bus.d_done = finish && grant_q[1];
   assign bus.i_q    = (expire && grant_q[0]) ? 32'd0 : bus.sdc_q;
   assign bus.d_q    = (expire && grant_q[1]) ? 32'd0 : bus.sdc_q;

   assign bus.sdc_addr    = lat.addr;
   assign bus.sdc_data    = lat.data;
   assign bus.sdc_we      = lat.we;
   assign bus.sdc_start   = sdc_start_q;
   assign bus.grant       = grant_q;
   assign bus.timeout_err = timeout_q;

   // Arbitration FSM: grant and latch in IDLE, hold the controller bus in
   // BUSY, then force one dead cycle so sdc_start always falls between jobs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         lat         <= '0;
         grant_q     <= 2'b00;
         sdc_start_q <= 1'b0;
         wd_cnt      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  lat         <= win_req;
                  grant_q     <= pick;
                  sdc_start_q <= 1'b1;
                  wd_cnt      <= '0;
                  state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               wd_cnt <= wd_cnt + CNT_W'(1);
               if (finish) begin
                  lat         <= '0;
                  grant_q     <= 2'b00;
                  sdc_start_q <= 1'b0;
                  state       <= ST_RELEASE;
                  if (expire)
                     timeout_q <= 1'b1;
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_sdram_arbiter.sv
// Directed bench for l1_sdram_arbiter. The DUT runs with an 8-cycle watchdog
// so the timeout path is reachable quickly. Inputs change on the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_l1_sdram_arbiter;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   l1_sdram_arbiter_if bus ();

   l1_sdram_arbiter #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10ns free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset values, including a stray sdc_done that must not reach any cache
   task automatic test_reset();
      reset = 1'b1;
      bus.i_addr = '0; bus.i_data = '0; bus.i_we = 1'b0; bus.i_start = 1'b0;
      bus.d_addr = '0; bus.d_data = '0; bus.d_we = 1'b0; bus.d_start = 1'b0;
      bus.sdc_q = 32'hAAAA_5555; bus.sdc_done = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 00", bus.grant); end
      checks++; if (bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdc_start: got %b expected 0", bus.sdc_start); end
      checks++; if (bus.sdc_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_sdc_addr: got %h expected 0", bus.sdc_addr); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done: got %b expected 00", {bus.i_done, bus.d_done}); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00) begin errors++; $display("[TB] FAIL idle_done_ignored: got %b expected 00", {bus.i_done, bus.d_done}); end
      @(negedge clk);
      bus.sdc_done = 1'b0;
   endtask

   // Single instruction-cache read answered after 5 BUSY cycles
   task automatic test_single_read();
      @(negedge clk);
      bus.i_addr = 32'h0000_0123; bus.i_we = 1'b0; bus.i_start = 1'b1;
      #1;
      checks++; if (bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL read_pre_start: got %b expected 0", bus.sdc_start); end
      @(negedge clk); #1;
      checks++; if (bus.sdc_start !== 1'b1) begin errors++; $display("[TB] FAIL read_sdc_start: got %b expected 1", bus.sdc_start); end
      checks++; if (bus.sdc_addr !== 32'h0000_0123) begin errors++; $display("[TB] FAIL read_sdc_addr: got %h expected 00000123", bus.sdc_addr); end
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("[TB] FAIL read_grant: got %b expected 01", bus.grant); end
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk); #1;
         checks++; if (bus.i_done !== 1'b0) begin errors++; $display("[TB] FAIL read_early_done cycle %0d: got %b expected 0", c, bus.i_done); end
      end
      @(negedge clk);
      bus.sdc_q = 32'hDEAD_BEEF; bus.sdc_done = 1'b1;
      #1;
      checks++; if (bus.i_done !== 1'b1) begin errors++; $display("[TB] FAIL read_i_done: got %b expected 1", bus.i_done); end
      checks++; if (bus.i_q !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_i_q: got %h expected deadbeef", bus.i_q); end
      checks++; if (bus.d_done !== 1'b0) begin errors++; $display("[TB] FAIL read_d_done: got %b expected 0", bus.d_done); end
      bus.i_start = 1'b0;
      @(negedge clk);
      bus.sdc_done = 1'b0;
      #1;
      checks++; if (bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL read_release_start: got %b expected 0", bus.sdc_start); end
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("[TB] FAIL read_release_grant: got %b expected 00", bus.grant); end
      checks++; if (bus.i_done !== 1'b0) begin errors++; $display("[TB] FAIL read_release_done: got %b expected 0", bus.i_done); end
      @(negedge clk);
   endtask

   // Both caches request continuously: D, I, D, I with a RELEASE+IDLE gap
   task automatic test_tie_alternation();
      logic [1:0]  exp_grant [4];
      logic [31:0] exp_addr;
      exp_grant = '{2'b10, 2'b01, 2'b10, 2'b01};
      @(negedge clk);
      bus.i_addr = 32'h100; bus.d_addr = 32'h200;
      bus.i_start = 1'b1; bus.d_start = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_addr = exp_grant[t][1] ? 32'h200 : 32'h100;
         @(negedge clk); #1;
         checks++; if (bus.grant !== exp_grant[t]) begin errors++; $display("[TB] FAIL tie_grant %0d: got %b expected %b", t, bus.grant, exp_grant[t]); end
         checks++; if (bus.sdc_start !== 1'b1 || bus.sdc_addr !== exp_addr) begin errors++; $display("[TB] FAIL tie_bus %0d: got start=%b addr=%h expected start=1 addr=%h", t, bus.sdc_start, bus.sdc_addr, exp_addr); end
         @(negedge clk);
         bus.sdc_done = 1'b1; bus.sdc_q = 32'(t);
         #1;
         checks++; if ({bus.d_done, bus.i_done} !== exp_grant[t]) begin errors++; $display("[TB] FAIL tie_done %0d: got %b expected %b", t, {bus.d_done, bus.i_done}, exp_grant[t]); end
         @(negedge clk);
         bus.sdc_done = 1'b0;
         #1;
         checks++; if (bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL tie_release_start %0d: got %b expected 0", t, bus.sdc_start); end
         @(negedge clk); #1;
         checks++; if (bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL tie_idle_start %0d: got %b expected 0", t, bus.sdc_start); end
         if (t == 3) begin
            bus.i_start = 1'b0; bus.d_start = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   // Request fields are captured at grant and survive input changes in BUSY
   task automatic test_latching();
      @(negedge clk);
      bus.d_addr = 32'h10; bus.d_data = 32'h55AA; bus.d_we = 1'b1; bus.d_start = 1'b1;
      @(negedge clk); #1;
      checks++; if (bus.grant !== 2'b10) begin errors++; $display("[TB] FAIL latch_grant: got %b expected 10", bus.grant); end
      checks++; if (bus.sdc_we !== 1'b1) begin errors++; $display("[TB] FAIL latch_we: got %b expected 1", bus.sdc_we); end
      bus.d_addr = 32'h20; bus.d_data = 32'h1234; bus.d_we = 1'b0; bus.d_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (bus.sdc_addr !== 32'h10 || bus.sdc_data !== 32'h55AA) begin errors++; $display("[TB] FAIL latch_hold %0d: got addr=%h data=%h expected 10/55aa", c, bus.sdc_addr, bus.sdc_data); end
      end
      @(negedge clk);
      bus.sdc_done = 1'b1;
      #1;
      checks++; if ({bus.d_done, bus.i_done} !== 2'b10) begin errors++; $display("[TB] FAIL latch_done: got %b expected 10", {bus.d_done, bus.i_done}); end
      @(negedge clk);
      bus.sdc_done = 1'b0;
      #1;
      checks++; if (bus.sdc_addr !== 32'd0 || bus.sdc_we !== 1'b0) begin errors++; $display("[TB] FAIL latch_release_clear: got addr=%h we=%b expected 0/0", bus.sdc_addr, bus.sdc_we); end
      @(negedge clk);
   endtask

   // Silent controller: watchdog ends the job on the 8th BUSY cycle
   task automatic test_watchdog();
      @(negedge clk);
      bus.i_addr = 32'h40; bus.i_we = 1'b0; bus.i_start = 1'b1;
      bus.sdc_q = 32'h1234_5678;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         if (c < 8) begin
            checks++; if (bus.i_done !== 1'b0 || bus.i_q !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wd_wait %0d: got done=%b q=%h expected 0/12345678", c, bus.i_done, bus.i_q); end
         end else begin
            checks++; if (bus.i_done !== 1'b1 || bus.i_q !== 32'd0) begin errors++; $display("[TB] FAIL wd_expire: got done=%b q=%h expected 1/0", bus.i_done, bus.i_q); end
            checks++; if (bus.d_done !== 1'b0 || bus.d_q !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wd_other_port: got done=%b q=%h expected 0/12345678", bus.d_done, bus.d_q); end
            checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL wd_err_early: got %b expected 0", bus.timeout_err); end
            bus.i_start = 1'b0;
         end
      end
      @(negedge clk); #1;
      checks++; if (bus.timeout_err !== 1'b1 || bus.sdc_start !== 1'b0) begin errors++; $display("[TB] FAIL wd_release: got err=%b start=%b expected 1/0", bus.timeout_err, bus.sdc_start); end
      @(negedge clk);
      bus.d_addr = 32'h80; bus.d_we = 1'b0; bus.d_start = 1'b1;
      @(negedge clk); #1;
      checks++; if (bus.grant !== 2'b10 || bus.sdc_addr !== 32'h80) begin errors++; $display("[TB] FAIL wd_next_grant: got grant=%b addr=%h expected 10/80", bus.grant, bus.sdc_addr); end
      @(negedge clk);
      bus.sdc_q = 32'hCAFE_F00D; bus.sdc_done = 1'b1;
      #1;
      checks++; if (bus.d_done !== 1'b1 || bus.d_q !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL wd_next_done: got done=%b q=%h expected 1/cafef00d", bus.d_done, bus.d_q); end
      bus.d_start = 1'b0;
      @(negedge clk);
      bus.sdc_done = 1'b0;
      #1;
      checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL wd_sticky: got %b expected 1", bus.timeout_err); end
      @(negedge clk);
   endtask

   // Reset in the middle of BUSY, followed by the abandoned job's done
   task automatic test_async_reset();
      @(negedge clk);
      bus.d_addr = 32'h300; bus.d_start = 1'b1;
      @(negedge clk); #1;
      checks++; if (bus.sdc_start !== 1'b1) begin errors++; $display("[TB] FAIL ar_busy: got %b expected 1", bus.sdc_start); end
      @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++; if (bus.sdc_start !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("[TB] FAIL ar_immediate: got start=%b grant=%b expected 0/00", bus.sdc_start, bus.grant); end
      checks++; if (bus.sdc_addr !== 32'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL ar_clear: got addr=%h err=%b expected 0/0", bus.sdc_addr, bus.timeout_err); end
      bus.d_start = 1'b0;
      bus.sdc_done = 1'b1;
      #1;
      checks++; if ({bus.d_done, bus.i_done} !== 2'b00) begin errors++; $display("[TB] FAIL ar_late_done_in_reset: got %b expected 00", {bus.d_done, bus.i_done}); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if ({bus.d_done, bus.i_done} !== 2'b00) begin errors++; $display("[TB] FAIL ar_late_done_after: got %b expected 00", {bus.d_done, bus.i_done}); end
      @(negedge clk);
      bus.sdc_done = 1'b0;
      #1;
      checks++; if (bus.sdc_start !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("[TB] FAIL ar_idle: got start=%b grant=%b expected 0/00", bus.sdc_start, bus.grant); end
   endtask

   // Scenario sequence
   initial begin
      errors = 0;
      checks = 0;
      $display("[TB] l1_sdram_arbiter directed tests");
      test_reset();
      test_single_read();
      test_tie_alternation();
      test_latching();
      test_watchdog();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
